// File: rtl/fxp_dot_accum.sv
// fxp_dot_accum: signed Q8.24 dot-product accumulator with a saturating result.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, len           job start and term count (sampled in IDLE only)
//   in_data/valid/ready  product stream from the multiplier
//   out_data/valid/ready result handshake; sat flags a clipped result
//   busy                 high whenever a job is in progress
// Build option: define FXP_DOT_ACCUM_SAT_EN for saturating clip and a live sat;
// without it the result wraps (low DATA_W bits of the accumulator) and sat is 0.
module fxp_dot_accum #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 24,
    parameter int LEN_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sat,
    output logic              busy
);

    // LEN_W guard bits hold up to 2^LEN_W-1 full-scale terms without wrapping.
    localparam int ACC_W = DATA_W + LEN_W;

    // The fractional position does not affect an aligned sum; only sanity-check it.
    if (FRAC_BITS < 0 || FRAC_BITS >= DATA_W) begin : g_bad_frac
        $error("fxp_dot_accum: FRAC_BITS must lie in [0, DATA_W)");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len_q;
    logic              take;
    logic              last;
    logic [DATA_W-1:0] res_data;
    logic              res_sat;

    // in_ready is a registered copy of (state == ACCUM).
    assign take    = in_valid && in_ready;
    assign acc_sum = acc + {{LEN_W{in_data[DATA_W-1]}}, in_data};
    assign last    = (count == len_q - LEN_W'(1));

`ifdef FXP_DOT_ACCUM_SAT_EN
    logic [LEN_W:0] hi;
    logic           fits;

    // The sum fits DATA_W iff every bit above the result's sign bit
    // equals that sign bit.
    assign hi   = acc_sum[ACC_W-1:DATA_W-1];
    assign fits = (&hi) || ~(|hi);

    always_comb begin
        res_data = acc_sum[DATA_W-1:0];
        res_sat  = 1'b0;
        if (!fits) begin
            res_sat = 1'b1;
            if (acc_sum[ACC_W-1]) begin
                res_data = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                res_data = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end
`else
    assign res_data = acc_sum[DATA_W-1:0];
    assign res_sat  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_data  <= '0;
                            sat       <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc   <= acc_sum;
                        count <= count + LEN_W'(1);
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_data  <= res_data;
                            sat       <= res_sat;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_dot_accum.sv
// tb_fxp_dot_accum: randomized and directed checks of fxp_dot_accum
// against a plain-arithmetic dot-product model.
module tb_fxp_dot_accum;

    localparam int DW = 32;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          sat;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] jt [32];

    fxp_dot_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact integer sum of the job's terms, then clip or wrap to 32 bits.
    function automatic void model(input int n, output logic [31:0] d,
                                  output logic s);
        longint sum;
        sum = 0;
        for (int k = 0; k < n; k++) sum += longint'($signed(jt[k]));
`ifdef FXP_DOT_ACCUM_SAT_EN
        if (sum > 64'sd2147483647) begin
            d = 32'h7FFF_FFFF;
            s = 1'b1;
        end else if (sum < -64'sd2147483648) begin
            d = 32'h8000_0000;
            s = 1'b1;
        end else begin
            d = sum[31:0];
            s = 1'b0;
        end
`else
        d = sum[31:0];
        s = 1'b0;
`endif
    endfunction

    task automatic run_job(input int n, input int gap_pct, input int bp,
                           input bit poke, input logic [6:0] pat,
                           input int pat_len);
        logic [31:0] ed;
        logic        es;
        int          i;
        int          cyc;
        int          pidx;
        bit          v;
        model(n, ed, es);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        start    = 1'b1;
        len      = n[4:0];
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        if (n == 0) check("zl_in_ready", in_ready, 0);
        i    = 0;
        pidx = 0;
        cyc  = 0;
        while (i < n && cyc < 500) begin
            check("acc_in_ready", in_ready, 1);
            check("acc_out_valid", out_valid, 0);
            if (pidx < pat_len) v = pat[pidx];
            else if (pat_len > 0) v = 1'b1;
            else v = ($urandom_range(99) >= gap_pct);
            pidx++;
            in_valid = v;
            in_data  = v ? jt[i] : $urandom();
            @(negedge clk);
            cyc++;
            if (v) i++;
        end
        in_valid = 1'b0;
        if (i < n) check("timeout", i, n);
        check("out_valid", out_valid, 1);
        check("out_data", out_data, ed);
        check("sat", sat, es);
        check("done_in_ready", in_ready, 0);
        check("done_busy", busy, 1);
        for (int b = 0; b < bp; b++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = $urandom();
            start     = poke;
            len       = 5'd3;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, ed);
            check("bp_sat", sat, es);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        start     = poke;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_busy", busy, 0);
        check("hs_in_ready", in_ready, 0);
    endtask

    initial begin
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum: 1.0 + 2.0 - 0.5 = 2.5.
        jt[0] = 32'h0100_0000;
        jt[1] = 32'h0200_0000;
        jt[2] = 32'hFF80_0000;
        run_job(3, 0, 0, 1'b0, 7'd0, 0);

        // Positive overflow: 3 x 127.0.
        for (int k = 0; k < 3; k++) jt[k] = 32'h7F00_0000;
        run_job(3, 0, 0, 1'b0, 7'd0, 0);

        // Negative overflow with two minimum terms.
        for (int k = 0; k < 31; k++) jt[k] = 32'h8000_0000;
        run_job(2, 0, 0, 1'b0, 7'd0, 0);

        // Full-length job of minimum terms exercises the guard bits.
        run_job(31, 0, 0, 1'b0, 7'd0, 0);

        // Zero-length job.
        run_job(0, 0, 1, 1'b0, 7'd0, 0);

        // Valid pattern 1,0,0,1,1,0,1 delivering exactly four terms.
        jt[0] = 32'h0040_0000;
        jt[1] = 32'hFFF0_0000;
        jt[2] = 32'h0300_0000;
        jt[3] = 32'h0001_2345;
        run_job(4, 0, 0, 1'b0, 7'b1011001, 7);

        // Back-pressure for 5 cycles with start pulsed during DONE.
        jt[0] = 32'h0123_4567;
        jt[1] = 32'hF000_0000;
        run_job(2, 0, 5, 1'b1, 7'd0, 0);

        // Next start after the ignored pokes is accepted normally.
        jt[0] = 32'h0080_0000;
        run_job(1, 0, 0, 1'b0, 7'd0, 0);

        // Async reset in the middle of a len=5 job.
        @(negedge clk);
        start = 1'b1;
        len   = 5'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h0700_0000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        jt[0] = 32'h0100_0000;
        run_job(1, 0, 0, 1'b0, 7'd0, 0);

        // Randomized jobs mixing full-range, extreme and small terms.
        for (int j = 0; j < 40; j++) begin
            int n;
            n = $urandom_range(31);
            for (int k = 0; k < n; k++) begin
                logic [31:0] r;
                r = $urandom();
                case ($urandom_range(2))
                    0: jt[k] = r;
                    1: jt[k] = r[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
                    default: jt[k] = {{6{r[25]}}, r[25:0]};
                endcase
            end
            run_job(n, $urandom_range(50), $urandom_range(3),
                    1'($urandom_range(1)), 7'd0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fxp_dot_accum.md
Name: fxp_dot_accum

Overview:
- Signed fixed-point dot-product accumulator that sits directly downstream of the Q8.24 fixed-point multiplier in the UKF datapath.
- Consumes a stream of Q8.24 products, one element pair per handshake, and sums a job of LEN terms.
- Emits one Q8.24 result per job, used for matrix-vector and matrix-matrix products in the sigma-point, covariance and gain computations.
- Saturates the final result to the 32-bit Q8.24 range.

Parameters:
- DATA_W, 32, width of the product input and the result (Q8.24).
- FRAC_BITS, 24, fractional bits; informational only, since the sum is alignment-free.
- LEN_W, 5, width of the job length; a job holds at most 2^LEN_W-1 terms.
- Localparam ACC_W = DATA_W+LEN_W, the internal accumulator width. Guard bits make internal overflow impossible.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a job; sampled only in IDLE
- len  input  LEN_W  number of terms in the job; sampled with start
- in_data  input  DATA_W  signed Q8.24 product from the multiplier
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data
- out_data  output  DATA_W  signed Q8.24 dot-product result
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- sat  output  1  out_data was clipped; qualified by out_valid
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, asynchronous active-low rst_n. Any assertion, including mid-job, immediately forces the following, and the in-progress job is discarded:
  - state to IDLE
  - acc, count, len_q to 0
  - out_data to 0; out_valid, sat, in_ready, busy to 0
- IDLE:
  - in_ready=0.
  - On start=1, latch len into len_q and clear acc and count.
  - If len==0, go to DONE with a zero result. Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each in_valid&&in_ready cycle adds sign-extend(in_data) to ACC_W, then adds it to acc, and increments count.
  - The term accepted when count==len_q-1 is the last term: go to DONE.
  - No handshake means acc and count hold.
- DONE entry, registered:
  - out_data = clip(acc) to the signed DATA_W range. Positive overflow gives 0x7FFF_FFFF; negative overflow gives 0x8000_0000.
  - sat = 1 iff clipping occurred.
  - out_valid = 1 on the cycle after the last term is accepted, or the cycle after start when len==0.
- DONE hold:
  - out_valid stays high and out_data and sat stay stable until out_ready=1.
  - On that handshake, clear out_valid and go to IDLE.
  - in_ready=0 throughout DONE.
- Ignored inputs:
  - start outside IDLE is ignored, including in the handshake cycle.
  - in_valid outside ACCUM is ignored, and no data is consumed.
- Throughput and latency:
  - One term per cycle.
  - Job latency is len+1 cycles from start to out_valid, with no back-pressure.
  - At least 1 idle cycle is needed between jobs, because start is sampled only in IDLE.
- Arithmetic: exact two's-complement integer sum. No rounding, since all terms share the Q8.24 scaling.

Optional Feature:
- Macro: FXP_DOT_ACCUM_SAT_EN.
- Defined: saturating clip as described above, and sat is driven.
- Undefined: out_data = acc[DATA_W-1:0] (wrap-around truncation), and sat is tied to 0.
- The guard bits and the internal accumulator are identical in both builds.

Test Plan:
- Basic sum: start, len=3, terms 0x0100_0000, 0x0200_0000, 0xFF80_0000 (1.0, 2.0, -0.5) in back-to-back cycles -> out_valid 1 cycle after the third term; out_data=0x0280_0000 (2.5); sat=0.
- Positive saturation: len=3, three terms of 0x7F00_0000 (127.0) -> with the macro, out_data=0x7FFF_FFFF and sat=1; without it, out_data=0x7D00_0000 and sat=0.
- Negative saturation and the guard-bit limit:
  - len=2, two terms of 0x8000_0000 -> with the macro, out_data=0x8000_0000 and sat=1.
  - len=31, all 0x8000_0000 -> acc is exact, with no internal wrap.
- Zero length and gaps:
  - len=0 -> out_valid next cycle with out_data=0, sat=0, and in_ready never asserted.
  - len=4 with in_valid toggled 1,0,0,1,1,0,1 -> sums only the 4 accepted terms.
- Back-pressure and ignored start:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data and sat stable, in_ready=0.
  - Pulse start during DONE -> ignored.
  - Raise out_ready -> return to IDLE, and the next start is accepted.
- Async reset mid-job: len=5 with 2 terms accepted, then assert rst_n low between clock edges -> outputs clear immediately. After release, a new len=1 job with 0x0100_0000 returns 0x0100_0000.
